// File: rtl/speed_test_frame_checker.sv
// Receive-side frame checker for the speed tester: classifies returning frames
// against a latched port configuration and accumulates good/bad/byte counters.
module speed_test_frame_checker #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  output logic                    s_axis_tready,
  input  logic                    start,
  input  logic                    stop,
  input  logic [191:0]            port_config,
  output logic                    check_ready,
  output logic [127:0]            check_results
);

  localparam int unsigned KEEP_W    = DATA_WIDTH / 8;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned BYTES_W   = 64;
  localparam int unsigned FB_W      = 17;
  localparam int unsigned CFG_W     = 112;
  localparam int unsigned HDR_BYTES = 12;
  localparam int unsigned POP_W     = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]         state_q,    state_d;
  logic               ready_q,    ready_d;
  logic [CFG_W-1:0]   cfg_q,      cfg_d;
  logic               in_frame_q, in_frame_d;
  logic               skip_q,     skip_d;
  logic [FB_W-1:0]    fbytes_q,   fbytes_d;
  logic               hdr_err_q,  hdr_err_d;
  logic               fmt_err_q,  fmt_err_d;
  logic [CNT_W-1:0]   good_q,     good_d;
  logic [CNT_W-1:0]   bad_q,      bad_d;
  logic [BYTES_W-1:0] gbytes_q,   gbytes_d;

  logic               last_beat;
  logic [POP_W-1:0]   keep_pop;
  logic               keep_contig;
  logic [FB_W:0]      fb_sum;
  logic [FB_W-1:0]    fb_next;
  logic               hdr_mis;
  logic               hdr_err_now;
  logic               fmt_err_now;
  logic               frame_bad;
  logic               count_en;
  logic [7:0]         exp_hdr [HDR_BYTES];
  logic               unused_cfg;

  assign s_axis_tready = 1'b1;
  assign check_ready   = ready_q;
  assign check_results = {gbytes_q, bad_q, good_q};
  assign unused_cfg    = ^port_config[191:CFG_W];

  assign last_beat   = s_axis_tvalid & s_axis_tlast;
  assign keep_pop    = POP_W'($countones(s_axis_tkeep));
  assign keep_contig = ((s_axis_tkeep & (s_axis_tkeep + KEEP_W'(1))) == KEEP_W'(0));

  // Saturate the per-frame byte count above 16 bits so it can never alias a valid length
  assign fb_sum  = {1'b0, fbytes_q} + (FB_W + 1)'(keep_pop);
  assign fb_next = fb_sum[FB_W] ? {FB_W{1'b1}} : fb_sum[FB_W-1:0];

  // Expected header in wire order: destination MAC then source MAC
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      exp_hdr[k]     = cfg_q[47 - 8*k -: 8];
      exp_hdr[k + 6] = cfg_q[95 - 8*k -: 8];
    end
  end

  // Compare every lane that falls inside the first twelve frame bytes
  always_comb begin
    logic [FB_W-1:0] pos;
    hdr_mis = 1'b0;
    pos     = '0;
    for (int i = 0; i < int'(KEEP_W); i++) begin
      pos = fbytes_q + FB_W'(i);
      if (pos < FB_W'(HDR_BYTES)) begin
        if (!s_axis_tkeep[i] || (s_axis_tdata[8*i +: 8] != exp_hdr[pos[3:0]])) begin
          hdr_mis = 1'b1;
        end
      end
    end
  end

  assign hdr_err_now = hdr_err_q | hdr_mis;
  assign fmt_err_now = fmt_err_q | ~keep_contig |
                       (~s_axis_tlast & (s_axis_tkeep != {KEEP_W{1'b1}}));
  assign frame_bad   = hdr_err_now | fmt_err_now | s_axis_tuser |
                       (fb_next != {1'b0, cfg_q[111:96]}) |
                       (fb_next < FB_W'(HDR_BYTES));
  assign count_en    = last_beat & ~skip_q & ~start &
                       ((state_q == ST_RUN) | (state_q == ST_DRAIN));

  // Next-state: control FSM, frame tracking and result counters
  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    in_frame_d = in_frame_q;
    skip_d     = skip_q;
    fbytes_d   = fbytes_q;
    hdr_err_d  = hdr_err_q;
    fmt_err_d  = fmt_err_q;
    good_d     = good_q;
    bad_d      = bad_q;
    gbytes_d   = gbytes_q;

    if (start) begin
      state_d = ST_RUN;
      cfg_d   = port_config[CFG_W-1:0];
    end else begin
      case (state_q)
        ST_RUN: begin
          if (stop) begin
            state_d = (in_frame_q && !last_beat) ? ST_DRAIN : ST_DONE;
          end
        end
        ST_DRAIN: begin
          if (last_beat) begin
            state_d = ST_DONE;
          end
        end
        default: state_d = state_q;
      endcase
    end

    if (s_axis_tvalid) begin
      in_frame_d = ~s_axis_tlast;
      if (s_axis_tlast) begin
        fbytes_d  = '0;
        hdr_err_d = 1'b0;
        fmt_err_d = 1'b0;
      end else begin
        fbytes_d  = fb_next;
        hdr_err_d = hdr_err_now;
        fmt_err_d = fmt_err_now;
      end
    end

    // A start that lands inside a frame discards the rest of that frame
    if (last_beat) begin
      skip_d = 1'b0;
    end else if (start && in_frame_q) begin
      skip_d = 1'b1;
    end

    if (start) begin
      good_d   = '0;
      bad_d    = '0;
      gbytes_d = '0;
    end else if (count_en) begin
      if (frame_bad) begin
        if (bad_q != {CNT_W{1'b1}}) bad_d = bad_q + CNT_W'(1);
      end else begin
        if (good_q != {CNT_W{1'b1}}) good_d = good_q + CNT_W'(1);
        gbytes_d = gbytes_q + BYTES_W'(fb_next);
      end
    end

    ready_d = (state_d == ST_IDLE) || (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      cfg_q      <= '0;
      in_frame_q <= 1'b0;
      skip_q     <= 1'b0;
      fbytes_q   <= '0;
      hdr_err_q  <= 1'b0;
      fmt_err_q  <= 1'b0;
      good_q     <= '0;
      bad_q      <= '0;
      gbytes_q   <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      cfg_q      <= cfg_d;
      in_frame_q <= in_frame_d;
      skip_q     <= skip_d;
      fbytes_q   <= fbytes_d;
      hdr_err_q  <= hdr_err_d;
      fmt_err_q  <= fmt_err_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      gbytes_q   <= gbytes_d;
    end
  end

endmodule

// File: tb/tb_speed_test_frame_checker.sv
// Scoreboard bench for speed_test_frame_checker: frames push expected counters,
// each test task pops and compares after the frame's tlast edge.
module tb_speed_test_frame_checker;

  localparam logic [47:0] DST     = 48'h02_00_00_00_00_01;
  localparam logic [47:0] SRC     = 48'h02_00_00_00_00_02;
  localparam logic [47:0] BAD_DST = 48'h02_00_00_00_00_09;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  s_axis_tdata;
  logic [7:0]   s_axis_tkeep;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic         s_axis_tuser;
  logic         s_axis_tready;
  logic         start;
  logic         stop;
  logic [191:0] port_config;
  logic         check_ready;
  logic [127:0] check_results;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] exp_q [$];
  logic [127:0] exp_v;
  logic [31:0]  m_good, m_bad;
  logic [63:0]  m_bytes;
  logic         m_run;
  logic [47:0]  c_dst;
  logic [15:0]  c_len;

  always #5 clk = ~clk;

  speed_test_frame_checker #(.DATA_WIDTH(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .start         (start),
    .stop          (stop),
    .port_config   (port_config),
    .check_ready   (check_ready),
    .check_results (check_results)
  );

  function automatic logic [7:0] frame_byte(input logic [47:0] d, input int k);
    logic [47:0] s;
    s = SRC;
    if (k < 6)       return d[47 - 8*k -: 8];
    else if (k < 12) return s[47 - 8*(k-6) -: 8];
    else             return 8'(k);
  endfunction

  function automatic logic [127:0] model_res();
    return {m_bytes, m_bad, m_good};
  endfunction

  task automatic do_start(input logic [15:0] len, input logic with_stop);
    port_config = {80'h0, len, SRC, DST};
    start = 1'b1;
    stop  = with_stop;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    c_dst = DST; c_len = len;
    m_good = '0; m_bad = '0; m_bytes = '0; m_run = 1'b1;
  endtask

  // Drives one frame; pushes the expected counters when the frame should be counted
  task automatic send_frame(input logic [47:0] d, input int nbytes, input logic bad_user,
                            input int sparse_beat, input int start_at, input int stop_at,
                            output logic pushed, output logic rdy_at_stop);
    int   nb, total;
    logic fmt_bad, skip, stop_seen, good;
    nb = (nbytes + 7) / 8;
    total = 0; fmt_bad = 1'b0; skip = 1'b0; stop_seen = 1'b0;
    pushed = 1'b0; rdy_at_stop = 1'b1;
    for (int b = 0; b < nb; b++) begin
      logic [7:0] keep;
      int rem;
      rem  = nbytes - 8*b;
      keep = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
      if (b == sparse_beat) keep = 8'h0F;
      for (int i = 0; i < 8; i++) s_axis_tdata[8*i +: 8] = frame_byte(d, 8*b + i);
      s_axis_tkeep  = keep;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (b == nb - 1);
      s_axis_tuser  = (b == nb - 1) ? bad_user : 1'b0;
      start = (b == start_at);
      stop  = (b == stop_at);
      total += $countones(keep);
      if (b != nb - 1 && keep != 8'hFF) fmt_bad = 1'b1;
      if (b == start_at) begin
        m_good = '0; m_bad = '0; m_bytes = '0; m_run = 1'b1; skip = 1'b1;
      end
      if (b == stop_at) stop_seen = 1'b1;
      if (b == nb - 1 && m_run && !skip) begin
        good = (d == c_dst) && (total == int'(c_len)) && (total >= 12) && !bad_user && !fmt_bad;
        if (good) begin
          if (m_good != 32'hFFFF_FFFF) m_good = m_good + 32'd1;
          m_bytes = m_bytes + 64'(total);
        end else if (m_bad != 32'hFFFF_FFFF) begin
          m_bad = m_bad + 32'd1;
        end
        exp_q.push_back(model_res());
        pushed = 1'b1;
      end
      @(posedge clk); #1;
      if (b == stop_at) rdy_at_stop = check_ready;
      start = 1'b0;
      stop  = 1'b0;
    end
    if (stop_seen) m_run = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0; s_axis_tkeep = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    start = 1'b0; stop = 1'b0; port_config = '0;
    m_good = '0; m_bad = '0; m_bytes = '0; m_run = 1'b0; c_dst = '0; c_len = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if (check_results !== 128'h0) begin n_err++; $display("FAIL reset_results: got %h want 0", check_results); end
    n_cmp++;
    if (check_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", check_ready); end
    n_cmp++;
    if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL tready: got %b want 1", s_axis_tready); end
  endtask

  task automatic test_good_frames();
    logic p, r;
    do_start(16'd64, 1'b0);
    n_cmp++;
    if (check_results !== 128'h0 || check_ready !== 1'b0) begin
      n_err++; $display("FAIL start_clear: got %h ready %b want 0 ready 0", check_results, check_ready);
    end
    for (int f = 0; f < 10; f++) begin
      send_frame(DST, 64, 1'b0, -1, -1, -1, p, r);
      n_cmp++;
      if (!p || exp_q.size() == 0) begin n_err++; $display("FAIL good_push: frame %0d not scored", f); end
      else begin
        exp_v = exp_q.pop_front();
        if (check_results !== exp_v) begin n_err++; $display("FAIL good_frame%0d: got %h want %h", f, check_results, exp_v); end
      end
    end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0; m_run = 1'b0;
    n_cmp++;
    if (check_ready !== 1'b1) begin n_err++; $display("FAIL stop_ready: got %b want 1", check_ready); end
    n_cmp++;
    if (check_results !== {64'd640, 32'd0, 32'd10}) begin
      n_err++; $display("FAIL good_totals: got %h want %h", check_results, {64'd640, 32'd0, 32'd10});
    end
    send_frame(DST, 64, 1'b0, -1, -1, -1, p, r);
    n_cmp++;
    if (p || check_results !== model_res()) begin
      n_err++; $display("FAIL done_stable: got %h want %h", check_results, model_res());
    end
  endtask

  task automatic test_bad_frames();
    logic p, r;
    do_start(16'd64, 1'b0);
    for (int f = 0; f < 4; f++) begin
      case (f)
        0:       send_frame(BAD_DST, 64, 1'b0, -1, -1, -1, p, r);
        1:       send_frame(DST,     63, 1'b0, -1, -1, -1, p, r);
        2:       send_frame(DST,     64, 1'b1, -1, -1, -1, p, r);
        default: send_frame(DST,     64, 1'b0,  2, -1, -1, p, r);
      endcase
      n_cmp++;
      if (!p || exp_q.size() == 0) begin n_err++; $display("FAIL bad_push: frame %0d not scored", f); end
      else begin
        exp_v = exp_q.pop_front();
        if (check_results !== exp_v) begin n_err++; $display("FAIL bad_frame%0d: got %h want %h", f, check_results, exp_v); end
      end
    end
    n_cmp++;
    if (check_results !== {64'd0, 32'd4, 32'd0}) begin
      n_err++; $display("FAIL bad_totals: got %h want %h", check_results, {64'd0, 32'd4, 32'd0});
    end
  endtask

  task automatic test_midframe_start();
    logic p, r;
    do_start(16'd64, 1'b0);
    send_frame(DST, 64, 1'b0, -1, 3, -1, p, r);
    n_cmp++;
    if (p || check_results !== 128'h0) begin n_err++; $display("FAIL skip_frame: got %h want 0", check_results); end
    send_frame(DST, 64, 1'b0, -1, -1, -1, p, r);
    n_cmp++;
    if (!p || exp_q.size() == 0) begin n_err++; $display("FAIL after_skip_push: not scored"); end
    else begin
      exp_v = exp_q.pop_front();
      if (check_results !== exp_v) begin n_err++; $display("FAIL after_skip: got %h want %h", check_results, exp_v); end
    end
  endtask

  task automatic test_stop_in_frame();
    logic p, r;
    do_start(16'd64, 1'b0);
    send_frame(DST, 64, 1'b0, -1, -1, 2, p, r);
    n_cmp++;
    if (r !== 1'b0) begin n_err++; $display("FAIL drain_ready: got %b want 0", r); end
    n_cmp++;
    if (!p || exp_q.size() == 0) begin n_err++; $display("FAIL drain_push: not scored"); end
    else begin
      exp_v = exp_q.pop_front();
      if (check_results !== exp_v || check_ready !== 1'b1) begin
        n_err++; $display("FAIL drain_final: got %h ready %b want %h ready 1", check_results, check_ready, exp_v);
      end
    end
  endtask

  task automatic test_saturation();
    logic p, r;
    do_start(16'd64, 1'b0);
    force dut.bad_q = 32'hFFFF_FFFE;
    @(posedge clk); #1;
    release dut.bad_q;
    m_bad = 32'hFFFF_FFFE;
    n_cmp++;
    if (check_results !== model_res()) begin n_err++; $display("FAIL preload: got %h want %h", check_results, model_res()); end
    for (int f = 0; f < 3; f++) begin
      send_frame(BAD_DST, 64, 1'b0, -1, -1, -1, p, r);
      n_cmp++;
      if (!p || exp_q.size() == 0) begin n_err++; $display("FAIL sat_push: frame %0d not scored", f); end
      else begin
        exp_v = exp_q.pop_front();
        if (check_results !== exp_v) begin n_err++; $display("FAIL sat_frame%0d: got %h want %h", f, check_results, exp_v); end
      end
    end
    do_start(16'd64, 1'b1);
    n_cmp++;
    if (check_results !== 128'h0 || check_ready !== 1'b0) begin
      n_err++; $display("FAIL start_stop: got %h ready %b want 0 ready 0", check_results, check_ready);
    end
    send_frame(DST, 64, 1'b0, -1, -1, -1, p, r);
    n_cmp++;
    if (!p || exp_q.size() == 0) begin n_err++; $display("FAIL start_wins_push: not scored"); end
    else begin
      exp_v = exp_q.pop_front();
      if (check_results !== exp_v) begin n_err++; $display("FAIL start_wins: got %h want %h", check_results, exp_v); end
    end
  endtask

  task automatic test_reset_midframe();
    logic p, r;
    do_start(16'd64, 1'b0);
    send_frame(DST, 64, 1'b0, -1, -1, -1, p, r);
    if (exp_q.size() != 0) exp_v = exp_q.pop_front();
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) s_axis_tdata[8*i +: 8] = frame_byte(DST, 8*b + i);
      s_axis_tkeep = 8'hFF; s_axis_tvalid = 1'b1; s_axis_tlast = 1'b0;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_good = '0; m_bad = '0; m_bytes = '0; m_run = 1'b0;
    n_cmp++;
    if (check_results !== 128'h0 || check_ready !== 1'b1) begin
      n_err++; $display("FAIL midframe_reset: got %h ready %b want 0 ready 1", check_results, check_ready);
    end
  endtask

  initial begin
    test_reset();
    test_good_frames();
    test_bad_frames();
    test_midframe_start();
    test_stop_in_frame();
    test_saturation();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
